// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor with elastic valid/ready flow control.
// The N-bit operation is split into STAGES register-separated segments of BLK-bit skip blocks.
module pipelined_carry_skip_adder #(
    parameter int N      = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         of
);

    localparam int W    = N / STAGES;
    localparam int NBLK = W / BLK;

    if (((N % (BLK * STAGES)) != 0) || (STAGES < 1) || (STAGES > (N / BLK))) begin : g_bad_params
        $error("pipelined_carry_skip_adder: N must be a multiple of BLK*STAGES");
    end

    // One W-bit segment: ripple inside each block, block carry bypasses when all bits propagate.
    function automatic logic [W:0] skip_add(
        input logic [W-1:0] x_s,
        input logic [W-1:0] y_s,
        input logic         c_in_s
    );
        logic [W-1:0] s_s;
        logic         blk_c_s;
        logic         rip_c_s;
        logic         prop_s;
        logic         p_bit_s;
        s_s     = {W{1'b0}};
        blk_c_s = c_in_s;
        for (int j = 0; j < NBLK; j++) begin
            rip_c_s = blk_c_s;
            prop_s  = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                p_bit_s            = x_s[j*BLK+i] ^ y_s[j*BLK+i];
                s_s[j*BLK+i]       = p_bit_s ^ rip_c_s;
                rip_c_s            = (x_s[j*BLK+i] & y_s[j*BLK+i]) | (p_bit_s & rip_c_s);
                prop_s             = prop_s & p_bit_s;
            end
            blk_c_s = prop_s ? blk_c_s : rip_c_s;
        end
        return {blk_c_s, s_s};
    endfunction

    // Per-stage state: operands still to be added, finished low sum bits, segment carry.
    logic [N-1:0]      a_r   [STAGES];
    logic [N-1:0]      bp_r  [STAGES];
    logic [N-1:0]      sum_r [STAGES];
    logic [STAGES-1:0] c_r;
    logic [STAGES-1:0] valid_r;
    logic              of_r;

    logic [N-1:0]      a_src_s   [STAGES];
    logic [N-1:0]      bp_src_s  [STAGES];
    logic [N-1:0]      sum_src_s [STAGES];
    logic [N-1:0]      sum_nxt_s [STAGES];
    logic [W:0]        slice_s   [STAGES];
    logic [STAGES-1:0] c_src_s;
    logic [STAGES-1:0] v_src_s;
    logic [STAGES-1:0] c_nxt_s;
    logic [STAGES-1:0] ready_s;
    logic              of_nxt_s;

    // Stage inputs: stage 0 sees the port operands, later stages see the previous register.
    always_comb begin
        c_src_s      = {STAGES{1'b0}};
        v_src_s      = {STAGES{1'b0}};
        a_src_s[0]   = a;
        bp_src_s[0]  = sub ? ~b : b;
        sum_src_s[0] = {N{1'b0}};
        c_src_s[0]   = sub ? 1'b1 : cin;
        v_src_s[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src_s[k]   = a_r[k-1];
            bp_src_s[k]  = bp_r[k-1];
            sum_src_s[k] = sum_r[k-1];
            c_src_s[k]   = c_r[k-1];
            v_src_s[k]   = valid_r[k-1];
        end
    end

    // Segment k adds slice k and merges it into the travelling partial sum.
    always_comb begin
        c_nxt_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            slice_s[k]             = skip_add(a_src_s[k][k*W +: W], bp_src_s[k][k*W +: W], c_src_s[k]);
            sum_nxt_s[k]           = sum_src_s[k];
            sum_nxt_s[k][k*W +: W] = slice_s[k][W-1:0];
            c_nxt_s[k]             = slice_s[k][W];
        end
        of_nxt_s = (a_src_s[STAGES-1][N-1] ~^ bp_src_s[STAGES-1][N-1])
                 & (sum_nxt_s[STAGES-1][N-1] ^ a_src_s[STAGES-1][N-1]);
    end

    // A stage can load when it is empty or its content moves on this cycle.
    always_comb begin
        ready_s           = {STAGES{1'b0}};
        ready_s[STAGES-1] = ~valid_r[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ready_s[k] = ~valid_r[k] | ready_s[k+1];
        end
    end

    // Pipeline registers; reset discards every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= {N{1'b0}};
                bp_r[k]  <= {N{1'b0}};
                sum_r[k] <= {N{1'b0}};
            end
            c_r     <= {STAGES{1'b0}};
            valid_r <= {STAGES{1'b0}};
            of_r    <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready_s[k]) begin
                    valid_r[k] <= v_src_s[k];
                    if (v_src_s[k]) begin
                        a_r[k]   <= a_src_s[k];
                        bp_r[k]  <= bp_src_s[k];
                        sum_r[k] <= sum_nxt_s[k];
                        c_r[k]   <= c_nxt_s[k];
                    end
                end
            end
            if (ready_s[STAGES-1] && v_src_s[STAGES-1]) begin
                of_r <= of_nxt_s;
            end
        end
    end

    assign in_ready  = ready_s[0] & ~rst;
    assign out_valid = valid_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign of        = of_r;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Bench for pipelined_carry_skip_adder: three configurations against an arithmetic
// reference model with a per-instance expected-result queue.
module tb_pipelined_carry_skip_adder;

    localparam int NI = 3;

    typedef struct packed {
        logic        ov;
        logic        co;
        logic [63:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid, in_ready, cin, sub, out_valid, out_ready, cout, of;
    logic [63:0] a_s   [NI];
    logic [63:0] b_s   [NI];
    logic [63:0] sum_o [NI];
    logic [31:0] sum0, sum2;
    logic [63:0] sum1;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   out_cnt [NI] = '{0, 0, 0};
    exp_t q [NI][$];
    logic [2:0] hold_pend = 3'b000;
    exp_t hold_val [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_carry_skip_adder #(.N(32), .BLK(4), .STAGES(2)) u_add32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_s[0][31:0]), .b(b_s[0][31:0]), .cin(cin[0]), .sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum0), .cout(cout[0]), .of(of[0]));

    pipelined_carry_skip_adder #(.N(64), .BLK(8), .STAGES(4)) u_add64 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_s[1]), .b(b_s[1]), .cin(cin[1]), .sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum1), .cout(cout[1]), .of(of[1]));

    pipelined_carry_skip_adder #(.N(32), .BLK(4), .STAGES(1)) u_add1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_s[2][31:0]), .b(b_s[2][31:0]), .cin(cin[2]), .sub(sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum2), .cout(cout[2]), .of(of[2]));

    always_comb begin
        sum_o[0] = {32'd0, sum0};
        sum_o[1] = sum1;
        sum_o[2] = {32'd0, sum2};
    end

    function automatic int nw(input int i);
        return (i == 1) ? 64 : 32;
    endfunction

    function automatic int ns(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 4 : 1);
    endfunction

    // Reference: plain wide arithmetic; overflow from the (n+1)-bit signed sum.
    function automatic exp_t model(input int n, input logic [63:0] av, input logic [63:0] bv,
                                   input logic c, input logic s);
        logic [63:0] mask, ax, bx;
        logic [65:0] us, sa, sb, ss;
        logic        ci;
        exp_t        r;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        ax   = av & mask;
        bx   = (s ? ~bv : bv) & mask;
        ci   = s ? 1'b1 : c;
        us   = {2'b00, ax} + {2'b00, bx} + {65'd0, ci};
        sa   = {2'b00, ax} | (ax[n-1] ? ~{2'b00, mask} : 66'd0);
        sb   = {2'b00, bx} | (bx[n-1] ? ~{2'b00, mask} : 66'd0);
        ss   = sa + sb + {65'd0, ci};
        r.s  = us[63:0] & mask;
        r.co = us[n];
        r.ov = ss[n] ^ ss[n-1];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: occupancy-derived in_ready, in-order results, output hold, reset flush.
    always @(negedge clk) begin
        exp_t e;
        exp_t cur;
        logic exp_rdy;
        for (int i = 0; i < NI; i++) begin
            cur = {of[i], cout[i], sum_o[i]};
            if (rst) begin
                check($sformatf("u%0d_rst_out_valid", i), 64'(out_valid[i]), 64'd0);
                check($sformatf("u%0d_rst_in_ready", i), 64'(in_ready[i]), 64'd0);
                q[i].delete();
                hold_pend[i] = 1'b0;
            end else begin
                if (hold_pend[i]) begin
                    check($sformatf("u%0d_hold_valid", i), 64'(out_valid[i]), 64'd1);
                    check($sformatf("u%0d_hold_sum", i), sum_o[i], hold_val[i].s);
                    check($sformatf("u%0d_hold_flags", i), 64'({of[i], cout[i]}),
                          64'({hold_val[i].ov, hold_val[i].co}));
                end
                exp_rdy = !((q[i].size() == ns(i)) && !out_ready[i]);
                check($sformatf("u%0d_in_ready", i), 64'(in_ready[i]), 64'(exp_rdy));
                if (out_valid[i]) begin
                    if (q[i].size() == 0) begin
                        check($sformatf("u%0d_spurious_out", i), 64'(out_valid[i]), 64'd0);
                    end else if (out_ready[i]) begin
                        e = q[i].pop_front();
                        check($sformatf("u%0d_sum", i), sum_o[i], e.s);
                        check($sformatf("u%0d_cout_of", i), 64'({of[i], cout[i]}), 64'({e.ov, e.co}));
                        out_cnt[i]++;
                    end
                end
                hold_pend[i] = out_valid[i] & ~out_ready[i];
                hold_val[i]  = cur;
                if (in_valid[i] && in_ready[i]) begin
                    q[i].push_back(model(nw(i), a_s[i], b_s[i], cin[i], sub[i]));
                end
            end
        end
    end

    // All helpers start and return one time unit after a rising edge.
    task automatic send(input int i, input logic [63:0] av, input logic [63:0] bv,
                        input logic c, input logic s);
        int n;
        n        = 0;
        a_s[i]   = av;
        b_s[i]   = bv;
        cin[i]   = c;
        sub[i]   = s;
        in_valid[i] = 1'b1;
        @(negedge clk);
        while (!in_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_send_accept", i), 64'(in_ready[i]), 64'd1);
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic one_shot(input string tag, input int i, input logic [63:0] av, input logic [63:0] bv,
                            input logic c, input logic s, input logic [63:0] es,
                            input logic eco, input logic eov);
        int n;
        send(i, av, bv, c, s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[i] && n < 20);
        check({tag, "_valid"}, 64'(out_valid[i]), 64'd1);
        check({tag, "_sum"}, sum_o[i], es);
        check({tag, "_cout_of"}, 64'({of[i], cout[i]}), 64'({eov, eco}));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (q[i].size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_drain", i), 64'(q[i].size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        logic [2:0] acc;
        int         start_cyc;
        int         cnt0;
        rst       = 1'b1;
        in_valid  = 3'b000;
        cin       = 3'b000;
        sub       = 3'b000;
        out_ready = 3'b111;
        pat       = 4'b1001;
        for (int i = 0; i < NI; i++) begin
            a_s[i] = 64'd0;
            b_s[i] = 64'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d_rst_sum", i), sum_o[i], 64'd0);
            check($sformatf("u%0d_rst_flags", i), 64'({of[i], cout[i]}), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check($sformatf("u%0d_post_rst_in_ready", i), 64'(in_ready[i]), 64'd1);
        @(posedge clk);
        #1;

        // 5+7+1 through two stages: invalid for one cycle, valid for exactly one.
        send(0, 64'd5, 64'd7, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_latency_gap", 64'(out_valid[0]), 64'd0);
        @(negedge clk);
        check("t1_valid", 64'(out_valid[0]), 64'd1);
        check("t1_sum", sum_o[0], 64'd13);
        check("t1_cout_of", 64'({of[0], cout[0]}), 64'd0);
        @(negedge clk);
        check("t1_one_cycle", 64'(out_valid[0]), 64'd0);
        @(posedge clk);
        #1;

        one_shot("t2_full_skip", 0, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        one_shot("t3_add_ovf", 0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
        one_shot("t3_sub_ovf", 0, 64'h8000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: k+k stream against an out_ready pattern 1,0,0,1.
        fork
            begin
                for (int k = 1; k <= 10; k++) send(0, 64'(k), 64'(k), 1'b0, 1'b0);
            end
            begin
                for (int p = 0; p < 60; p++) begin
                    out_ready[0] = pat[p % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready[0] = 1'b1;
        drain(0);

        // Throughput: 100 back-to-back beats must take exactly 100 cycles.
        start_cyc = cyc;
        cnt0      = out_cnt[0];
        for (int k = 0; k < 100; k++) send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
        check("t5_cycles", 64'(cyc - start_cyc), 64'd100);
        drain(0);
        check("t5_count", 64'(out_cnt[0] - cnt0), 64'd100);

        // Random traffic with random stalls on all three configurations.
        for (int cyc_i = 0; cyc_i < 400; cyc_i++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (!in_valid[i] || acc[i]) begin
                    in_valid[i] = ($urandom_range(3, 0) != 0);
                    a_s[i]      = {$urandom, $urandom};
                    b_s[i]      = ($urandom_range(7, 0) == 0) ? ~a_s[i] : {$urandom, $urandom};
                    cin[i]      = 1'($urandom);
                    sub[i]      = 1'($urandom);
                end
                out_ready[i] = ($urandom_range(3, 0) != 0);
            end
        end
        in_valid  = 3'b000;
        out_ready = 3'b001;
        drain(0);

        // Reset with beats in flight everywhere; nothing stale may appear afterwards.
        send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 3'b111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) check($sformatf("u%0d_t6_no_stale", i), 64'(out_valid[i]), 64'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            one_shot($sformatf("u%0d_t6_after_rst", i), i, 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);
        end
        for (int i = 0; i < NI; i++) drain(i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
